// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the 80x30 text VGA controller.
//   VRAM_ADDR_W / VRAM_DATA_W : video-RAM address and data widths
//   WR_FIFO_DEPTH             : default depth of the CPU write queue
//   vram_wr_t                 : {addr, data} write record passed to the VGA stage
//   h_max / v_max             : total horizontal / vertical counts per frame
// -----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_ADDR_W   = 15;
    localparam int VRAM_DATA_W   = 8;
    localparam int WR_FIFO_DEPTH = 8;

    localparam int h_max = 800;
    localparam int v_max = 525;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous, idle-high bus strobe, with a third
// flop used to detect the rising (deasserting) edge of the synchronized signal.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset; all stages reset to 1 (bus idle)
//   d_async in  asynchronous input
//   q       out synchronized level (second stage)
//   rise    out one-cycle pulse when q has just gone 0 -> 1
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// vram_wr_fifo
// Captures Z80 writes into the video-RAM window and queues {address, data}
// pairs for the VGA stage's once-per-character CPU write slot.
// Ports:
//   CLK_50, nRST          clock, asynchronous active-low reset
//   CPU_A, CPU_D          Z80 address/data (asynchronous)
//   CPU_nWR, CPU_nCS      Z80 write strobe / window select (asynchronous)
//   WR_A, WR_D, WR_VALID  show-ahead head entry and not-empty flag
//   WR_ACK                pop pulse from the VGA stage
//   FIFO_LEVEL            occupancy (registered)
//   FIFO_AFULL            FIFO_LEVEL >= AF_LEVEL (registered)
//   OVERFLOW, OVF_CLR     sticky dropped-write flag and its clear
//   CPU_nWAIT             Z80 wait request, active low
// Optional feature: define VRAM_WR_WAIT_EN to drive CPU_nWAIT from the
// almost-full flag (registered); otherwise CPU_nWAIT is tied high.
// -----------------------------------------------------------------------------
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int DEPTH    = WR_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     CLK_50,
    input  logic                     nRST,
    input  logic [ADDR_W-1:0]        CPU_A,
    input  logic [DATA_W-1:0]        CPU_D,
    input  logic                     CPU_nWR,
    input  logic                     CPU_nCS,
    output logic [ADDR_W-1:0]        WR_A,
    output logic [DATA_W-1:0]        WR_D,
    output logic                     WR_VALID,
    input  logic                     WR_ACK,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic                     FIFO_AFULL,
    output logic                     OVERFLOW,
    input  logic                     OVF_CLR,
    output logic                     CPU_nWAIT
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    // Strobe synchronization
    logic nwr_s2, nwr_rise;
    logic ncs_s1_q, ncs_s2_q, ncs_s1_d, ncs_s2_d;

    sync_edge u_nwr_sync (
        .clk     (CLK_50),
        .rst_n   (nRST),
        .d_async (CPU_nWR),
        .q       (nwr_s2),
        .rise    (nwr_rise)
    );

    // Hold registers and queue state
    logic [ADDR_W-1:0] hold_a_q, hold_a_d;
    logic [DATA_W-1:0] hold_d_q, hold_d_d;
    logic              hold_vld_q, hold_vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic capture, push_req, pop, full, push;
    logic [EW-1:0] head;

    always_comb begin
        ncs_s1_d   = CPU_nCS;
        ncs_s2_d   = ncs_s1_q;

        // Keep re-sampling while the strobe is low so the value committed is
        // the last one seen before the strobe deasserts.
        capture    = ~nwr_s2 & ~ncs_s2_q;
        push_req   = nwr_rise & hold_vld_q;
        pop        = WR_ACK & (level_q != '0);
        full       = (level_q == LW'(DEPTH));
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push       = push_req & (~full | pop);

        hold_a_d   = hold_a_q;
        hold_d_d   = hold_d_q;
        hold_vld_d = hold_vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;

        if (capture) begin
            hold_a_d   = CPU_A;
            hold_d_d   = CPU_D;
            hold_vld_d = 1'b1;
        end else if (push_req) begin
            hold_vld_d = 1'b0;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        afull_d = (level_d >= LW'(AF_LEVEL));

        // A new drop takes priority over a clear in the same cycle.
        if (push_req && !push)
            ovf_d = 1'b1;
        else if (OVF_CLR)
            ovf_d = 1'b0;
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            ncs_s1_q   <= 1'b1;
            ncs_s2_q   <= 1'b1;
            hold_a_q   <= '0;
            hold_d_q   <= '0;
            hold_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ncs_s1_q   <= ncs_s1_d;
            ncs_s2_q   <= ncs_s2_d;
            hold_a_q   <= hold_a_d;
            hold_d_q   <= hold_d_d;
            hold_vld_q <= hold_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset; outputs are masked while the queue is empty.
    always_ff @(posedge CLK_50) begin
        if (push) mem_q[wr_ptr_q] <= {hold_a_q, hold_d_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign WR_VALID   = (level_q != '0);
    assign WR_A       = WR_VALID ? head[EW-1:DATA_W] : '0;
    assign WR_D       = WR_VALID ? head[DATA_W-1:0]  : '0;
    assign FIFO_LEVEL = level_q;
    assign FIFO_AFULL = afull_q;
    assign OVERFLOW   = ovf_q;

`ifdef VRAM_WR_WAIT_EN
    logic nwait_q, nwait_d;

    always_comb begin
        nwait_d = ~afull_q;
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) nwait_q <= 1'b1;
        else       nwait_q <= nwait_d;
    end

    assign CPU_nWAIT = nwait_q;
`else
    assign CPU_nWAIT = 1'b1;
`endif

endmodule

// File: tb/tb_vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// tb_vram_wr_fifo
// Directed testbench for vram_wr_fifo: latency, ordering, full/overflow,
// simultaneous push+pop at full, nCS filtering, asynchronous reset, and the
// CPU_nWAIT behaviour (expectation follows VRAM_WR_WAIT_EN).
// -----------------------------------------------------------------------------
module tb_vram_wr_fifo;

    logic        CLK_50  = 1'b0;
    logic        nRST    = 1'b0;
    logic [14:0] CPU_A   = '0;
    logic [7:0]  CPU_D   = '0;
    logic        CPU_nWR = 1'b1;
    logic        CPU_nCS = 1'b1;
    logic        WR_ACK  = 1'b0;
    logic        OVF_CLR = 1'b0;
    logic [14:0] WR_A;
    logic [7:0]  WR_D;
    logic        WR_VALID;
    logic [3:0]  FIFO_LEVEL;
    logic        FIFO_AFULL;
    logic        OVERFLOW;
    logic        CPU_nWAIT;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef VRAM_WR_WAIT_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    vram_wr_fifo dut (
        .CLK_50     (CLK_50),
        .nRST       (nRST),
        .CPU_A      (CPU_A),
        .CPU_D      (CPU_D),
        .CPU_nWR    (CPU_nWR),
        .CPU_nCS    (CPU_nCS),
        .WR_A       (WR_A),
        .WR_D       (WR_D),
        .WR_VALID   (WR_VALID),
        .WR_ACK     (WR_ACK),
        .FIFO_LEVEL (FIFO_LEVEL),
        .FIFO_AFULL (FIFO_AFULL),
        .OVERFLOW   (OVERFLOW),
        .OVF_CLR    (OVF_CLR),
        .CPU_nWAIT  (CPU_nWAIT)
    );

    always #10 CLK_50 = ~CLK_50;

    // Z80 write: strobe low for 4 cycles, then held data/select for 3 more
    // cycles so the commit edge has passed when the task returns (at a negedge).
    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input logic ncs);
        CPU_A   = a;
        CPU_D   = d;
        CPU_nCS = ncs;
        CPU_nWR = 1'b0;
        repeat (4) @(negedge CLK_50);
        CPU_nWR = 1'b1;
        repeat (3) @(negedge CLK_50);
        CPU_nCS = 1'b1;
        $display("[TB] write A=%h D=%h nCS=%0b -> level=%0d ovf=%0b", a, d, ncs, FIFO_LEVEL, OVERFLOW);
    endtask

    task automatic ack_pulse;
        WR_ACK = 1'b1;
        @(negedge CLK_50);
        WR_ACK = 1'b0;
        $display("[TB] ack -> level=%0d valid=%0b", FIFO_LEVEL, WR_VALID);
    endtask

    task automatic test_reset;
        #25;
        n_tests++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", WR_VALID); end
        n_tests++; if (FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); end
        n_tests++; if (WR_A !== 15'h0 || WR_D !== 8'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", WR_A, WR_D); end
        n_tests++; if (OVERFLOW !== 1'b0 || FIFO_AFULL !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ovf=%0b afull=%0b want 0/0", OVERFLOW, FIFO_AFULL); end
        n_tests++; if (CPU_nWAIT !== 1'b1) begin n_fail++; $display("FAIL reset_nwait: got %0b want 1", CPU_nWAIT); end
        @(negedge CLK_50);
        nRST = 1'b1;
        @(negedge CLK_50);
        $display("[TB] reset released");
    endtask

    task automatic test_single;
        CPU_A = 15'h1234; CPU_D = 8'hA5; CPU_nCS = 1'b0; CPU_nWR = 1'b0;
        repeat (10) @(negedge CLK_50);
        CPU_nWR = 1'b1;
        repeat (2) @(negedge CLK_50);
        n_tests++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL single_early: valid=%0b after 2nd edge, want 0", WR_VALID); end
        @(negedge CLK_50);
        n_tests++; if (WR_VALID !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid=%0b after 3rd edge, want 1", WR_VALID); end
        n_tests++; if (WR_A !== 15'h1234 || WR_D !== 8'hA5) begin n_fail++; $display("FAIL single_head: got %h/%h want 1234/a5", WR_A, WR_D); end
        n_tests++; if (FIFO_LEVEL !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", FIFO_LEVEL); end
        CPU_nCS = 1'b1;
        $display("[TB] single write A=1234 D=a5 queued");
        ack_pulse();
        n_tests++; if (WR_VALID !== 1'b0 || FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL single_pop: valid=%0b level=%0d want 0/0", WR_VALID, FIFO_LEVEL); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 8; i++) cpu_write(15'h0100 + 15'(i), 8'(i), 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd8) begin n_fail++; $display("FAIL fill_level: got %0d want 8", FIFO_LEVEL); end
        n_tests++; if (FIFO_AFULL !== 1'b1 || OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL fill_flags: afull=%0b ovf=%0b want 1/0", FIFO_AFULL, OVERFLOW); end
        cpu_write(15'h0108, 8'h08, 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", FIFO_LEVEL); end
        n_tests++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", OVERFLOW); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (WR_D !== 8'(i) || WR_A !== 15'h0100 + 15'(i)) begin
                n_fail++; $display("FAIL fill_order[%0d]: got %h/%h want %h/%h", i, WR_A, WR_D, 15'h0100 + 15'(i), 8'(i));
            end
            ack_pulse();
        end
        n_tests++; if (WR_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL drain_state: valid=%0b ovf=%0b want 0/1", WR_VALID, OVERFLOW); end
        OVF_CLR = 1'b1;
        @(negedge CLK_50);
        OVF_CLR = 1'b0;
        $display("[TB] ovf_clr -> ovf=%0b", OVERFLOW);
        n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %0b want 0", OVERFLOW); end
    endtask

    task automatic test_full_simul;
        for (int i = 0; i < 8; i++) cpu_write(15'h0200 + 15'(i), 8'(i), 1'b0);
        // 9th write: raise WR_ACK exactly on the commit edge.
        CPU_A = 15'h0208; CPU_D = 8'h08; CPU_nCS = 1'b0; CPU_nWR = 1'b0;
        repeat (4) @(negedge CLK_50);
        CPU_nWR = 1'b1;
        repeat (2) @(negedge CLK_50);
        WR_ACK = 1'b1;
        @(negedge CLK_50);
        WR_ACK = 1'b0;
        CPU_nCS = 1'b1;
        $display("[TB] write A=0208 D=08 with ack at full -> level=%0d ovf=%0b", FIFO_LEVEL, OVERFLOW);
        n_tests++; if (FIFO_LEVEL !== 4'd8) begin n_fail++; $display("FAIL simul_level: got %0d want 8", FIFO_LEVEL); end
        n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %0b want 0", OVERFLOW); end
        for (int i = 1; i <= 8; i++) begin
            n_tests++;
            if (WR_D !== 8'(i) || WR_A !== 15'h0200 + 15'(i)) begin
                n_fail++; $display("FAIL simul_order[%0d]: got %h/%h want %h/%h", i, WR_A, WR_D, 15'h0200 + 15'(i), 8'(i));
            end
            ack_pulse();
        end
        n_tests++; if (FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL simul_drain: got %0d want 0", FIFO_LEVEL); end
    endtask

    task automatic test_nocs;
        cpu_write(15'h0555, 8'h33, 1'b1);
        n_tests++; if (FIFO_LEVEL !== 4'd0 || WR_VALID !== 1'b0) begin n_fail++; $display("FAIL nocs_push: level=%0d valid=%0b want 0/0", FIFO_LEVEL, WR_VALID); end
        ack_pulse();
        n_tests++; if (FIFO_LEVEL !== 4'd0 || WR_VALID !== 1'b0 || WR_A !== 15'h0 || OVERFLOW !== 1'b0) begin
            n_fail++; $display("FAIL empty_ack: level=%0d valid=%0b A=%h ovf=%0b want 0/0/0/0", FIFO_LEVEL, WR_VALID, WR_A, OVERFLOW);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) cpu_write(15'h0300 + 15'(i), 8'h40 + 8'(i), 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd3) begin n_fail++; $display("FAIL rst_pre_level: got %0d want 3", FIFO_LEVEL); end
        #3 nRST = 1'b0;
        #2;
        $display("[TB] async reset asserted -> level=%0d valid=%0b", FIFO_LEVEL, WR_VALID);
        n_tests++; if (WR_VALID !== 1'b0 || FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL rst_async: valid=%0b level=%0d want 0/0", WR_VALID, FIFO_LEVEL); end
        @(negedge CLK_50);
        nRST = 1'b1;
        @(negedge CLK_50);
        cpu_write(15'h0777, 8'h5A, 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd1 || WR_A !== 15'h0777 || WR_D !== 8'h5A) begin
            n_fail++; $display("FAIL rst_after: level=%0d head=%h/%h want 1/0777/5a", FIFO_LEVEL, WR_A, WR_D);
        end
        ack_pulse();
    endtask

    task automatic test_wait;
        for (int i = 0; i < 6; i++) cpu_write(15'h0400 + 15'(i), 8'h80 + 8'(i), 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd6 || FIFO_AFULL !== 1'b0 || CPU_nWAIT !== 1'b1) begin
            n_fail++; $display("FAIL wait_l6: level=%0d afull=%0b nwait=%0b want 6/0/1", FIFO_LEVEL, FIFO_AFULL, CPU_nWAIT);
        end
        cpu_write(15'h0406, 8'h86, 1'b0);
        n_tests++; if (FIFO_LEVEL !== 4'd7 || FIFO_AFULL !== 1'b1 || CPU_nWAIT !== 1'b1) begin
            n_fail++; $display("FAIL wait_l7: level=%0d afull=%0b nwait=%0b want 7/1/1", FIFO_LEVEL, FIFO_AFULL, CPU_nWAIT);
        end
        @(negedge CLK_50);
        n_tests++; if (CPU_nWAIT !== ~WAIT_EN) begin n_fail++; $display("FAIL wait_assert: nwait=%0b want %0b", CPU_nWAIT, ~WAIT_EN); end
        ack_pulse();
        n_tests++; if (FIFO_LEVEL !== 4'd6 || FIFO_AFULL !== 1'b0 || CPU_nWAIT !== ~WAIT_EN) begin
            n_fail++; $display("FAIL wait_pop: level=%0d afull=%0b nwait=%0b want 6/0/%0b", FIFO_LEVEL, FIFO_AFULL, CPU_nWAIT, ~WAIT_EN);
        end
        @(negedge CLK_50);
        n_tests++; if (CPU_nWAIT !== 1'b1) begin n_fail++; $display("FAIL wait_release: nwait=%0b want 1", CPU_nWAIT); end
        repeat (6) ack_pulse();
        n_tests++; if (FIFO_LEVEL !== 4'd0) begin n_fail++; $display("FAIL wait_drain: got %0d want 0", FIFO_LEVEL); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_simul();
        test_nocs();
        test_reset_mid();
        test_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_wr_fifo.md
Name: vram_wr_fifo

Overview:
- Upstream stage of the 80x30 text VGA controller.
- Captures Z80 writes to the video-RAM window and queues {address, data} pairs in a small FIFO.
- Presents one entry at a time to the VGA stage's CPU write slot, which is granted once per 8-pixel character (every 16 CLK_50 cycles).
- Decouples asynchronous Z80 bus timing from the CLK_50 domain, so back-to-back CPU writes are not lost between write slots.

Parameters:
- ADDR_W, 15, video-RAM address width.
- DATA_W, 8, data width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-1, occupancy at which FIFO_AFULL asserts.

Ports:
- CLK_50  in  1  50 MHz system clock.
- nRST  in  1  asynchronous active-low reset.
- CPU_A  in  ADDR_W  Z80 address, asynchronous.
- CPU_D  in  DATA_W  Z80 data, asynchronous, input only.
- CPU_nWR  in  1  Z80 write strobe, asynchronous.
- CPU_nCS  in  1  video-RAM window select, decoded externally, asynchronous.
- WR_A  out  ADDR_W  head-entry address.
- WR_D  out  DATA_W  head-entry data.
- WR_VALID  out  1  FIFO not empty.
- WR_ACK  in  1  one-cycle pop pulse from the VGA stage.
- FIFO_LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- FIFO_AFULL  out  1  FIFO_LEVEL >= AF_LEVEL.
- OVERFLOW  out  1  sticky dropped-write flag.
- OVF_CLR  in  1  clears OVERFLOW.
- CPU_nWAIT  out  1  Z80 wait request, active low.

Behaviour:
- Clock and reset: single clock CLK_50; nRST is asynchronous, active-low.
- Reset values:
  - FIFO empty, FIFO_LEVEL=0, WR_VALID=0.
  - WR_A=0, WR_D=0, OVERFLOW=0, FIFO_AFULL=0, CPU_nWAIT=1.
  - Synchronizer stages reset to 1 (bus idle).
- Synchronizers:
  - CPU_nWR and CPU_nCS each pass through 2 flops (s1, s2).
  - A third flop s3 on nWR provides edge detection.
- Capture:
  - Every CLK_50 edge with s2_nWR=0 and s2_nCS=0, the hold registers load CPU_A and CPU_D.
  - The last sample is therefore taken while the strobe is still low.
- Commit:
  - A push request is raised when s2_nWR=1, s3_nWR=0, and the hold-valid bit is set.
  - Hold-valid is set by any capture and cleared by the commit.
  - Pulses with nCS high never commit.
- Latency:
  - Push occurs on the 3rd CLK_50 rising edge after CPU_nWR rises, counting the first sampling edge as 1.
  - WR_VALID is high immediately after that edge when the FIFO was empty.
- Output side:
  - Show-ahead: WR_A and WR_D always reflect the head entry while WR_VALID=1.
  - WR_ACK with WR_VALID=1 pops on that edge.
  - WR_ACK while empty is ignored; no underflow and no state change.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and FIFO_LEVEL is unchanged.
  - This holds when full; the push is accepted because the pop frees a slot.
- Full:
  - Push without pop when FIFO_LEVEL=DEPTH: the entry is dropped and OVERFLOW is set.
  - FIFO contents are unchanged.
- OVERFLOW:
  - Cleared by OVF_CLR=1.
  - If OVF_CLR and a new overflow occur in the same cycle, set wins.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- FIFO_LEVEL and FIFO_AFULL are registered and update on the same edge as the push or pop.
- Reset mid-write: an asserted nRST discards the queue and hold registers. A Z80 write whose strobe rises after nRST deasserts commits normally only if a capture occurred after reset.

Optional Feature:
- Macro: VRAM_WR_WAIT_EN.
- Defined:
  - CPU_nWAIT = ~FIFO_AFULL, registered.
  - Stalls the Z80 before the FIFO fills, so overflow is impossible with compliant CPU timing.
- Undefined:
  - CPU_nWAIT is tied to 1.
  - Overflow drops data and sets OVERFLOW.

Decomposition:
- Package vram_pkg holds:
  - VRAM_ADDR_W=15, VRAM_DATA_W=8, WR_FIFO_DEPTH=8.
  - Packed typedef vram_wr_t {addr, data}, shared with the VGA stage.
  - Timing localparams h_max=800, v_max=525.
- One sub-module, sync_edge: 2-flop synchronizer with reset value 1, plus registered rising-edge detect. Instantiated for nWR; nCS uses the synchronizer only.

Test Plan:
- Single write, CPU_A=0x1234, CPU_D=0xA5, nWR low for 10 cycles -> WR_VALID rises on the 3rd edge after nWR rises; WR_A=0x1234, WR_D=0xA5; WR_ACK pulse -> WR_VALID=0, FIFO_LEVEL=0.
- 8 writes (data 0x00..0x07), no ACK -> FIFO_LEVEL=8, FIFO_AFULL=1. 9th write -> dropped, OVERFLOW=1. Popping yields 0x00..0x07 in order. OVF_CLR -> OVERFLOW=0.
- FIFO full, 9th commit coincident with WR_ACK -> FIFO_LEVEL stays 8, OVERFLOW=0, last popped entry is 0x07+1 data.
- Write strobe with CPU_nCS=1 -> no push, FIFO_LEVEL=0. WR_ACK while empty -> no change.
- nRST asserted with 3 queued entries -> WR_VALID=0, FIFO_LEVEL=0 asynchronously. Next write after release -> normal push.
- VRAM_WR_WAIT_EN defined -> CPU_nWAIT goes 0 the cycle after FIFO_LEVEL reaches 7, and returns to 1 after the pop to 6.
